// File: rtl/wave_pkg.sv
// wave_pkg: shared mode encodings, unity gain and the sine table generator for wave_gen
package wave_pkg;

    typedef enum logic [1:0] {
        MODE_TRI = 2'd0,
        MODE_SAW = 2'd1,
        MODE_SQR = 2'd2,
        MODE_SIN = 2'd3
    } mode_e;

    localparam logic [8:0] AMP_UNITY = 9'd256;

    // Offset-binary full-wave sine entry idx of a 2^aw table, dw-bit output.
    // Quarter-wave symmetry plus a Q30 Taylor series keeps this integer-only
    // so the table folds to constants at elaboration.
    function automatic int sine_entry(input int idx, input int aw, input int dw);
        longint pi_q;
        longint x;
        longint x2;
        longint term;
        longint s;
        longint v;
        int qn;
        int quad;
        int r;
        int k;
        pi_q = 64'sd3373259426;
        qn   = 1 << (aw - 2);
        quad = idx / qn;
        r    = idx % qn;
        k    = quad[0] ? qn - r : r;
        x    = (2 * pi_q * k) >>> aw;
        x2   = (x * x) >>> 30;
        term = x;
        s    = x;
        for (int n = 1; n <= 6; n++) begin
            term = -((term * x2) >>> 30) / (2 * n * (2 * n + 1));
            s    = s + term;
        end
        v = (s * ((64'sd1 << (dw - 1)) - 1) + (64'sd1 << 29)) >>> 30;
        return (1 << (dw - 1)) + (quad[1] ? -int'(v) : int'(v));
    endfunction

endpackage

// File: rtl/sine_lut.sv
// sine_lut: full-wave offset-binary sine ROM with a registered one-cycle read
module sine_lut
    import wave_pkg::*;
#(
    parameter int TBL_AW = 9,
    parameter int DAC_W  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [TBL_AW-1:0] addr,
    output logic [DAC_W-1:0]  data
);

    logic [DAC_W-1:0] rom [2**TBL_AW];

    for (genvar i = 0; i < 2**TBL_AW; i++) begin : g_rom
        localparam logic [DAC_W-1:0] V = DAC_W'(sine_entry(i, TBL_AW, DAC_W));
        assign rom[i] = V;
    end

    // Read register doubles as the sine path's waveform stage; it freezes with en.
    always_ff @(posedge clk) begin
        if (rst)
            data <= '0;
        else if (en)
            data <= rom[addr];
    end

endmodule

// File: rtl/wave_gen.sv
// wave_gen: two-channel DDS with shadowed config, four waveforms and amplitude scaling
module wave_gen
    import wave_pkg::*;
#(
    parameter int ACC_W  = 24,
    parameter int DAC_W  = 14,
    parameter int PH_W   = 8,
    parameter int TBL_AW = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [ACC_W-1:0] freq,
    input  logic [8:0]       amp,
    input  logic [PH_W-1:0]  phase,
    input  logic [1:0]       mode,
    input  logic             cfg_ld,
    input  logic             sync,
    output logic             cfg_busy,
    output logic [DAC_W-1:0] DA_A,
    output logic [DAC_W-1:0] DA_B
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic             wrap;
    logic             apply;
    logic [ACC_W-1:0] sh_freq, act_freq;
    logic [8:0]       sh_amp, act_amp;
    logic [PH_W-1:0]  sh_phase, act_phase;
    mode_e            sh_mode, act_mode, mode_q;
    logic [DAC_W:0]   pa_top, pb_top;
    logic [8:0]       gain;
    logic [DAC_W-1:0] wa, wb, sa, sb, oa, ob;

    // Only the top DAC_W+1 phase bits feed the shapers; the channel-B offset has
    // zero low bits, so adding it to that slice alone matches a full-width add.
    assign sum    = {1'b0, acc} + {1'b0, act_freq};
    assign wrap   = en & sum[ACC_W];
    assign apply  = cfg_busy & (wrap | sync);
    assign pa_top = acc[ACC_W-1 -: DAC_W+1];
    assign pb_top = pa_top + {act_phase, {(DAC_W+1-PH_W){1'b0}}};
    assign gain   = act_amp > AMP_UNITY ? AMP_UNITY : act_amp;
    assign DA_A   = en ? oa : '0;
    assign DA_B   = en ? ob : '0;

    function automatic logic [DAC_W-1:0] shape(input logic [DAC_W:0] u, input mode_e m);
        return m == MODE_TRI ? (u[DAC_W] ? ~u[DAC_W-1:0] : u[DAC_W-1:0]) :
               m == MODE_SAW ? u[DAC_W:1] : {DAC_W{u[DAC_W]}};
    endfunction

    // Flipping the MSB converts offset-binary to two's complement about midscale
    // and back; the arithmetic shift gives the floored divide by 256.
    function automatic logic [DAC_W-1:0] scale(input logic [DAC_W-1:0] w, input logic [8:0] a);
        logic signed [DAC_W+9:0] p;
        logic [DAC_W-1:0]        q;
        p = (DAC_W+10)'($signed({~w[DAC_W-1], w[DAC_W-2:0]})) * (DAC_W+10)'($signed({1'b0, a}));
        q = DAC_W'(p >>> 8);
        return {~q[DAC_W-1], q[DAC_W-2:0]};
    endfunction

    sine_lut #(.TBL_AW(TBL_AW), .DAC_W(DAC_W)) u_lut_a (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .addr (pa_top[DAC_W -: TBL_AW]),
        .data (sa)
    );

    sine_lut #(.TBL_AW(TBL_AW), .DAC_W(DAC_W)) u_lut_b (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .addr (pb_top[DAC_W -: TBL_AW]),
        .data (sb)
    );

    // Phase accumulator: sync restarts it even while paused, en gates stepping.
    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (sync)
            acc <= '0;
        else if (en)
            acc <= sum[ACC_W-1:0];
    end

    // Shadow/active config: a load on the apply edge lands in the shadow and waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_freq   <= '0;
            sh_amp    <= '0;
            sh_phase  <= '0;
            sh_mode   <= MODE_TRI;
            act_freq  <= '0;
            act_amp   <= '0;
            act_phase <= '0;
            act_mode  <= MODE_TRI;
            cfg_busy  <= 1'b0;
        end else begin
            if (apply) begin
                act_freq  <= sh_freq;
                act_amp   <= sh_amp;
                act_phase <= sh_phase;
                act_mode  <= sh_mode;
            end
            if (cfg_ld) begin
                sh_freq  <= freq;
                sh_amp   <= amp;
                sh_phase <= phase;
                sh_mode  <= mode_e'(mode);
            end
            cfg_busy <= cfg_ld | (cfg_busy & ~apply);
        end
    end

    // Waveform stage then scaled output stage; mode_q tracks which stage-2 source is live.
    always_ff @(posedge clk) begin
        if (rst) begin
            wa     <= '0;
            wb     <= '0;
            mode_q <= MODE_TRI;
            oa     <= '0;
            ob     <= '0;
        end else if (en) begin
            wa     <= shape(pa_top, act_mode);
            wb     <= shape(pb_top, act_mode);
            mode_q <= act_mode;
            oa     <= scale(mode_q == MODE_SIN ? sa : wa, gain);
            ob     <= scale(mode_q == MODE_SIN ? sb : wb, gain);
        end
    end

endmodule

// File: doc/wave_gen.md
WAVE_GEN -- requirements
Module: wave_gen

Interface
REQ-001 SHALL have parameter ACC_W, default 24: phase accumulator and frequency-word width.
REQ-002 SHALL have parameter DAC_W, default 14: output sample width, unsigned offset-binary, midscale 2^(DAC_W-1).
REQ-003 SHALL have parameter PH_W, default 8: channel-B phase-offset width.
REQ-004 SHALL have parameter TBL_AW, default 9: sine table address width.
REQ-005 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port en, input, 1: run enable.
REQ-008 SHALL have port freq, input, ACC_W: phase step per clk.
REQ-009 SHALL have port amp, input, 9: gain = amp/256; values above 256 clamp to 256.
REQ-010 SHALL have port phase, input, PH_W: channel-B offset added to accumulator top PH_W bits.
REQ-011 SHALL have port mode, input, 2: 0 triangle, 1 sawtooth, 2 square, 3 sine.
REQ-012 SHALL have port cfg_ld, input, 1: one-cycle strobe capturing freq/amp/phase/mode into shadow registers.
REQ-013 SHALL have port sync, input, 1: forces phase restart.
REQ-014 SHALL have port cfg_busy, output, 1: shadow config pending.
REQ-015 SHALL have port DA_A, output, DAC_W: channel-A sample.
REQ-016 SHALL have port DA_B, output, DAC_W: channel-B sample.

Function
REQ-017 SHALL, while en=1, add active freq to acc every cycle, modulo 2^ACC_W; wrap = carry-out of that add.
REQ-018 SHALL, while en=0, hold acc and pipeline and drive DA_A/DA_B to 0 combinationally.
REQ-019 SHALL derive channel-A phase pa = acc; channel-B phase pb = acc + (active phase << (ACC_W-PH_W)), modulo 2^ACC_W.
REQ-020 SHALL, with u = top DAC_W+1 bits of phase, form triangle = u[MSB] ? ~u[DAC_W-1:0] : u[DAC_W-1:0].
REQ-021 SHALL form sawtooth = top DAC_W bits of phase.
REQ-022 SHALL form square = phase MSB ? 2^DAC_W-1 : 0.
REQ-023 SHALL form sine = sine_lut entry at top TBL_AW bits of phase.
REQ-024 SHALL form scaled out = mid + floor(((w - mid) * amp) / 256), w = waveform sample, signed arithmetic, result always within 0..2^DAC_W-1.
REQ-025 SHALL pipeline: stage 1 acc register, stage 2 waveform register, stage 3 scaled output register; latency acc to DA is 2 cycles after stage 1, i.e. the sample for acc=0 appears 3 cycles after rst release with en=1.
REQ-026 SHALL, on cfg_ld, load shadow registers and set cfg_busy=1 the next cycle.
REQ-027 SHALL, on cfg_ld while cfg_busy=1, overwrite the shadow; only the last value is applied.
REQ-028 SHALL, on the first wrap after the shadow is loaded, copy shadow to active config and clear cfg_busy; a cfg_ld coinciding with a wrap is applied at the following wrap.
REQ-029 SHALL, on sync=1, set acc=0 next cycle and apply any pending shadow as if a wrap occurred; sync with cfg_ld applies the old shadow and leaves the new one pending.
REQ-030 SHALL, in the startup state and with active amp=0, output midscale on both channels when en=1.

Reset
REQ-031 SHALL, on rst=1, clear acc, pipeline registers, shadow and active config (freq, amp, phase, mode = 0), cfg_busy=0 and DA_A=DA_B=0 the next cycle, regardless of pending config.
REQ-032 SHALL give rst priority over sync, cfg_ld and en.

Structure
REQ-033 SHALL place mode encodings and the amp unity constant (256) in shared package wave_pkg.
REQ-034 SHALL instantiate sub-module sine_lut twice (one per channel): 2^TBL_AW x DAC_W, registered one-cycle read, full-wave offset-binary.

Verification
REQ-035 SHALL cover: rst, then cfg_ld mode=1, freq=0x010000, amp=256, sync -> DA_A = 0, 64, 128, ... increasing by 64 per cycle.
REQ-036 SHALL cover: mode=2, freq=0x100000, amp=256, phase=128 -> DA_A 8 cycles 0 / 8 cycles 16383; DA_B the exact complement.
REQ-037 SHALL cover: square, amp=128 -> levels 4096 and 12287; amp=300 -> 0 and 16383; amp=0 -> 8192 constant.
REQ-038 SHALL cover: cfg_ld new freq mid-period -> cfg_busy high, old step retained until wrap, new step from wrap cycle onward; cfg_ld on wrap cycle -> applied one period later.
REQ-039 SHALL cover: en low for 5 cycles -> DA=0, acc frozen; resume continues from held phase.
REQ-040 SHALL cover: rst asserted while cfg_busy=1 -> next cycle cfg_busy=0, DA=0, acc=0; pending config discarded.
